// File: rtl/wb_host_bridge.sv
// Wishbone classic slave bridging the management bus to a firmware memory port
// and a small control register file (core reset, timeout status, scratch).
module wb_host_bridge #(
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
    parameter int unsigned MEM_AW    = 10,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              core_rst_o,
    output logic              irq_o
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REG, S_MREQ, S_MWAIT} state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic              r_ack;
    logic [31:0]       r_dat;
    logic              r_req;
    logic              r_we;
    logic [3:0]        r_be;
    logic [MEM_AW-1:0] r_addr;
    logic [31:0]       r_wdat;
    logic [1:0]        r_ctrl;
    logic              r_status;
    logic [31:0]       r_scratch;

    logic              w_hit, w_accept, w_cnt_last, w_busy;
    logic              w_ack_wr, w_ack_rd, w_timeout, w_req_drop;
    logic              w_reg_wr, w_status_clr;
    logic [31:0]       w_rd_data;
    logic              w_unused;

    assign w_hit      = (wbs_adr_i[31:17] == ADDR_BASE[31:17]);
    assign w_accept   = (r_state == S_IDLE) && wbs_cyc_i && wbs_stb_i && !r_ack && w_hit;
    assign w_cnt_last = (r_cnt == CW'(TIMEOUT - 1));
    assign w_busy     = (r_state == S_MREQ) || (r_state == S_MWAIT);
    assign w_unused   = ^wbs_adr_i[15:0];

    // Register writes land in REG (the ack cycle), using the operands latched on accept.
    assign w_reg_wr     = (r_state == S_REG) && r_we;
    assign w_status_clr = w_reg_wr && (r_addr[1:0] == 2'd1) && r_be[0] && r_wdat[0];

    always_comb begin
        w_rd_data = '0;
        case (wbs_adr_i[3:2])
            2'd0:    w_rd_data = {30'd0, r_ctrl};
            2'd1:    w_rd_data = {31'd0, r_status};
            2'd2:    w_rd_data = r_scratch;
            default: w_rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ack_wr    = 1'b0;
        w_ack_rd    = 1'b0;
        w_timeout   = 1'b0;
        w_req_drop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = wbs_adr_i[16] ? S_REG : S_MREQ;
            end
            S_REG: w_state_nxt = S_IDLE;
            S_MREQ: begin
                if (!wbs_cyc_i) begin
                    w_req_drop  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (mem_gnt_i && r_we) begin
                    w_req_drop  = 1'b1;
                    w_ack_wr    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_cnt_last) begin
                    // A read granted on the last allowed cycle cannot return in time.
                    w_req_drop  = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (mem_gnt_i) begin
                    w_req_drop  = 1'b1;
                    w_state_nxt = S_MWAIT;
                end
            end
            S_MWAIT: begin
                if (!wbs_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else if (mem_rvalid_i) begin
                    w_ack_rd    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_cnt_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack     <= 1'b0;
            r_dat     <= '0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_addr    <= '0;
            r_wdat    <= '0;
            r_cnt     <= '0;
            r_ctrl    <= 2'b01;
            r_status  <= 1'b0;
            r_scratch <= '0;
        end else begin
            r_ack <= 1'b0;
            if (w_accept) begin
                r_we   <= wbs_we_i;
                r_be   <= wbs_sel_i;
                r_addr <= wbs_adr_i[MEM_AW+1:2];
                r_wdat <= wbs_dat_i;
                r_cnt  <= '0;
                if (wbs_adr_i[16]) begin
                    r_ack <= 1'b1;
                    r_dat <= w_rd_data;
                end else begin
                    r_req <= 1'b1;
                end
            end
            if (w_busy)     r_cnt <= r_cnt + 1'b1;
            if (w_req_drop) r_req <= 1'b0;
            if (w_ack_wr)   r_ack <= 1'b1;
            if (w_ack_rd) begin
                r_ack <= 1'b1;
                r_dat <= mem_rdata_i;
            end
            if (w_timeout) begin
                r_ack <= 1'b1;
                if (!r_we) r_dat <= 32'hDEAD_BEEF;
            end
            if (w_reg_wr && (r_addr[1:0] == 2'd0) && r_be[0]) r_ctrl <= r_wdat[1:0];
            if (w_reg_wr && (r_addr[1:0] == 2'd2)) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (r_be[i]) r_scratch[i*8 +: 8] <= r_wdat[i*8 +: 8];
                end
            end
            // Timeout set takes priority over a same-cycle write-1-to-clear.
            r_status <= (r_status && !w_status_clr) || w_timeout;
        end
    end

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_be_o    = r_be;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdat;
    assign core_rst_o  = r_ctrl[0];
    assign irq_o       = r_status && r_ctrl[1];

endmodule
